// File: rtl/obf_indexgen_cam_pkg.sv
// rtl/obf_indexgen_cam_pkg.sv - shared widths and helpers for the obfuscation index tables
package obf_indexgen_cam_pkg;

   localparam int OBF_INDEX_WIDTH = 8;
   localparam logic [OBF_INDEX_WIDTH-1:0] OBF_INDEX_MISS = '1;

   // Entry-number width; a single-entry table still needs a 1-bit address.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/obf_prio_enc.sv
// rtl/obf_prio_enc.sv - hit vector to lowest set entry number plus any-hit flag
module obf_prio_enc #(
   parameter int N  = 32,
   parameter int IW = 5
) (
   input  logic [N-1:0]  hits,
   output logic [IW-1:0] first,
   output logic          any
);

   // Scan from the top so the lowest-numbered hit is the last one written.
   always_comb begin
      first = '0;
      any   = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (hits[i]) begin
            first = IW'(i);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/obf_indexgen_cam.sv
// rtl/obf_indexgen_cam.sv - programmable mask/match table mapping instruction words to obfuscation indices
module obf_indexgen_cam
   import obf_indexgen_cam_pkg::*;
#(
   parameter int INSN_WIDTH     = 32,
   parameter int INDEX_WIDTH    = OBF_INDEX_WIDTH,
   parameter int ENTRIES        = 32,
   parameter int MISS_CNT_WIDTH = 16,
   localparam int AW            = addr_width(ENTRIES)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INSN_WIDTH-1:0]     insn,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [INDEX_WIDTH-1:0]    out_index,
   output logic                      out_hit,
   input  logic                      cfg_we,
   input  logic [AW-1:0]             cfg_addr,
   input  logic                      cfg_valid,
   input  logic [INSN_WIDTH-1:0]     cfg_mask,
   input  logic [INSN_WIDTH-1:0]     cfg_match,
   input  logic [INDEX_WIDTH-1:0]    cfg_index,
   input  logic                      cfg_clr,
   output logic [MISS_CNT_WIDTH-1:0] miss_cnt
);

   logic [ENTRIES-1:0]     ent_valid;
   logic [INSN_WIDTH-1:0]  ent_mask  [ENTRIES];
   logic [INSN_WIDTH-1:0]  ent_match [ENTRIES];
   logic [INDEX_WIDTH-1:0] ent_index [ENTRIES];

   logic                   s1_valid;
   logic [INSN_WIDTH-1:0]  s1_insn;
   logic                   en;
   logic                   cfg_wr;
   logic [ENTRIES-1:0]     hits;
   logic [AW-1:0]          first;
   logic                   any;

   assign en       = !out_valid || out_ready;
   assign in_ready = en || !s1_valid;
   assign cfg_wr   = cfg_we && !cfg_clr;

   // Compare runs on the registered S1 word against the pre-write table contents.
   always_comb begin
      hits = '0;
      for (int e = 0; e < ENTRIES; e++) begin
         hits[e] = ent_valid[e] && (((s1_insn ^ ent_match[e]) & ent_mask[e]) == '0);
      end
   end

   obf_prio_enc #(
      .N  (ENTRIES),
      .IW (AW)
   ) u_prio (
      .hits  (hits),
      .first (first),
      .any   (any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_valid <= '0;
      end else if (cfg_clr) begin
         ent_valid <= '0;
      end else if (cfg_we) begin
         for (int e = 0; e < ENTRIES; e++) begin
            if (cfg_addr == AW'(e)) ent_valid[e] <= cfg_valid;
         end
      end
   end

   // Out-of-range addresses match no entry and are dropped.
   always_ff @(posedge clk) begin
      if (cfg_wr) begin
         for (int e = 0; e < ENTRIES; e++) begin
            if (cfg_addr == AW'(e)) begin
               ent_mask[e]  <= cfg_mask;
               ent_match[e] <= cfg_match;
               ent_index[e] <= cfg_index;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_insn  <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) s1_insn <= insn;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_hit   <= 1'b0;
         out_index <= '1;
      end else if (en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_hit   <= any;
            out_index <= any ? ent_index[first] : '1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_cnt <= '0;
      end else if (cfg_clr) begin
         miss_cnt <= '0;
      end else if (out_valid && out_ready && !out_hit && (miss_cnt != '1)) begin
         miss_cnt <= miss_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_obf_indexgen_cam.sv
// tb/tb_obf_indexgen_cam.sv - self-checking bench for obf_indexgen_cam
module tb_obf_indexgen_cam;
   import obf_indexgen_cam_pkg::*;

   localparam int IW = OBF_INDEX_WIDTH;
   localparam int NE = 32;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   insn = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [IW-1:0] out_index;
   logic          out_hit;
   logic          cfg_we = 1'b0;
   logic [4:0]    cfg_addr = '0;
   logic          cfg_valid = 1'b0;
   logic [31:0]   cfg_mask = '0;
   logic [31:0]   cfg_match = '0;
   logic [IW-1:0] cfg_index = '0;
   logic          cfg_clr = 1'b0;
   logic [MW-1:0] miss_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   obf_indexgen_cam #(
      .INSN_WIDTH     (32),
      .INDEX_WIDTH    (IW),
      .ENTRIES        (NE),
      .MISS_CNT_WIDTH (MW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .insn      (insn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_hit   (out_hit),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_valid (cfg_valid),
      .cfg_mask  (cfg_mask),
      .cfg_match (cfg_match),
      .cfg_index (cfg_index),
      .cfg_clr   (cfg_clr),
      .miss_cnt  (miss_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Reference table: the first valid entry whose masked bits equal the word wins.
   logic [NE-1:0] mv = '0;
   logic [31:0]   mk [NE];
   logic [31:0]   mm [NE];
   logic [IW-1:0] mi [NE];
   logic [IW:0]   expq [$];
   int            mmiss = 0;

   function automatic logic [IW:0] model_lookup(input logic [31:0] w);
      for (int e = 0; e < NE; e++) begin
         if (mv[e] && ((w ^ mm[e]) & mk[e]) == 32'd0) return {1'b1, mi[e]};
      end
      return {1'b0, OBF_INDEX_MISS};
   endfunction

   // A word's result is fixed by the table as it stands once the word has been taken in.
   always @(posedge clk) begin
      if (!rst_n) begin
         mv = '0;
         expq.delete();
         mmiss = 0;
      end else begin
         if (cfg_clr) mmiss = 0;
         else if (out_valid && out_ready && !out_hit && mmiss < (1 << MW) - 1) mmiss++;
         if (cfg_clr) begin
            mv = '0;
         end else if (cfg_we && int'(cfg_addr) < NE) begin
            mv[cfg_addr] = cfg_valid;
            mk[cfg_addr] = cfg_mask;
            mm[cfg_addr] = cfg_match;
            mi[cfg_addr] = cfg_index;
         end
         if (in_valid && in_ready) expq.push_back(model_lookup(insn));
      end
   end

   logic          prev_stall = 1'b0;
   logic [IW-1:0] prev_idx = '0;
   logic          prev_hit = 1'b0;
   logic [IW:0]   exp_res;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         chk("miss_cnt_model", miss_cnt, mmiss);
         if (prev_stall) begin
            chk("stall_valid_held", out_valid, 1);
            chk("stall_index_held", out_index, prev_idx);
            chk("stall_hit_held", out_hit, prev_hit);
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL out_unexpected actual=index 0x%0h expected=no result", out_index);
            end else begin
               exp_res = expq.pop_front();
               chk("out_hit_model", out_hit, exp_res[IW]);
               chk("out_index_model", out_index, exp_res[IW-1:0]);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_idx   = out_index;
         prev_hit   = out_hit;
      end
   end

   task automatic cfg_write(input int a, input logic v, input logic [31:0] mask,
                            input logic [31:0] match, input int idx);
      @(posedge clk); #1;
      cfg_we    = 1'b1;
      cfg_addr  = a[4:0];
      cfg_valid = v;
      cfg_mask  = mask;
      cfg_match = match;
      cfg_index = idx[IW-1:0];
      @(posedge clk); #1;
      cfg_we    = 1'b0;
   endtask

   task automatic lookup(input string name, input logic [31:0] w, input logic h,
                         input logic [IW-1:0] idx);
      @(posedge clk); #1;
      in_valid = 1'b1;
      insn     = w;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({name, "_not_yet"}, out_valid, 0);
      @(posedge clk); #1;
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_hit"}, out_hit, h);
      chk({name, "_index"}, out_index, idx);
   endtask

   logic [31:0] stream [8];
   int          sidx;
   bit          acc;

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      stream = '{32'h15000000, 32'h9C000000, 32'hE0000000, 32'hB8000000,
                 32'h14FFFFFF, 32'hE3FFFFFF, 32'h00000000, 32'h17000001};
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_hit", out_hit, 0);
      chk("reset_out_index", out_index, 8'hFF);
      chk("reset_miss_cnt", miss_cnt, 0);

      lookup("empty_table", 32'h15000000, 1'b0, 8'hFF);
      @(posedge clk); #1;
      chk("miss_after_first", miss_cnt, 1);

      cfg_write(3, 1'b1, 32'hFC000000, 32'h14000000, 4);
      lookup("lnop_hit", 32'h15000000, 1'b1, 8'd4);
      lookup("addi_miss", 32'h9C000000, 1'b0, 8'hFF);

      cfg_write(1, 1'b1, 32'hFC000000, 32'hE0000000, 64);
      cfg_write(5, 1'b1, 32'h00000000, 32'h00000000, 99);
      lookup("overlap_e1", 32'hE0000000, 1'b1, 8'd64);
      lookup("overlap_catchall", 32'hB8000000, 1'b1, 8'd99);
      lookup("overlap_prio_e3", 32'h15000000, 1'b1, 8'd4);

      @(posedge clk); #1;
      sidx = 0;
      for (int c = 0; c < 40 && (sidx < 8 || expq.size() > 0); c++) begin
         in_valid = (sidx < 8);
         if (sidx < 8) insn = stream[sidx];
         out_ready = !(c >= 3 && c <= 5);
         @(negedge clk);
         if (c == 3) chk("stream_in_ready_full", in_ready, 0);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) sidx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_all_accepted", sidx, 8);
      chk("stream_drained", expq.size(), 0);

      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_clr = 1'b1; cfg_addr = 5'd7; cfg_valid = 1'b1;
      cfg_mask = 32'hFFFFFFFF; cfg_match = 32'h12345678; cfg_index = 8'd7;
      @(posedge clk); #1;
      cfg_we = 1'b0; cfg_clr = 1'b0;
      chk("clr_miss_zero", miss_cnt, 0);
      lookup("clr_wins_over_we", 32'h12345678, 1'b0, 8'hFF);

      @(posedge clk); #1;
      in_valid = 1'b1; insn = 32'hAAAA0000;
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_addr = 5'd0; cfg_valid = 1'b1;
      cfg_mask = 32'hFFFFFFFF; cfg_match = 32'hAAAA0000; cfg_index = 8'd10;
      @(posedge clk); #1;
      cfg_we = 1'b0; in_valid = 1'b0;
      chk("wr_same_cycle_old_hit", out_hit, 0);
      chk("wr_same_cycle_old_index", out_index, 8'hFF);
      @(posedge clk); #1;
      chk("wr_next_new_hit", out_hit, 1);
      chk("wr_next_new_index", out_index, 8'd10);

      @(posedge clk); #1;
      cfg_clr = 1'b1;
      @(posedge clk); #1;
      cfg_clr = 1'b0;
      for (int k = 0; k < (1 << MW) + 3; k++) begin
         in_valid = 1'b1;
         insn     = 32'h100 * k;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("miss_saturated", miss_cnt, 4'hF);

      cfg_write(2, 1'b1, 32'h00000000, 32'h00000000, 5);
      @(posedge clk); #1;
      in_valid = 1'b1; insn = 32'h11111111;
      @(posedge clk); #1;
      insn = 32'h22222222;
      @(posedge clk); #1;
      insn = 32'h33333333;
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_in_ready", in_ready, 1);
      chk("midreset_miss_cnt", miss_cnt, 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      lookup("post_reset_invalid", 32'h00000000, 1'b0, 8'hFF);

      repeat (3) @(posedge clk);
      #1 chk("final_queue_empty", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
